// File: rtl/qupls_rename_stage_pkg.sv
// Shared types and sizing for the QUPLS rename stage: register spec widths,
// register-file sizes and the renamed-operand bundle handed to dispatch.
package qupls_rename_stage_pkg;

  localparam int NAREG = 64;
  localparam int NPREG = 128;
  localparam int NFREE = NPREG - NAREG;

  typedef logic [5:0] regspec_t;
  typedef logic [6:0] pregspec_t;

  typedef struct packed {
    pregspec_t pRa;
    pregspec_t pRb;
    pregspec_t pRt;
    pregspec_t pRt_old;
  } rename_out_t;

endpackage

// File: rtl/qupls_rename_stage_if.sv
// Decode/dispatch/commit signal bundle of the rename stage. The master side
// is the decoder and commit logic; the slave side is the rename stage.
interface qupls_rename_stage_if;
  import qupls_rename_stage_pkg::*;

  logic        dec_v;
  logic        dec_rdy;
  regspec_t    Ra;
  regspec_t    Rb;
  regspec_t    Rt;
  logic        Rt_v;
  logic        ren_v;
  logic        ren_rdy;
  pregspec_t   pRa;
  pregspec_t   pRb;
  pregspec_t   pRt;
  pregspec_t   pRt_old;
  logic        cmt_v;
  pregspec_t   cmt_preg;
  logic [6:0]  free_cnt;
  logic        fl_err;

  modport master (
    output dec_v, Ra, Rb, Rt, Rt_v, ren_rdy, cmt_v, cmt_preg,
    input  dec_rdy, ren_v, pRa, pRb, pRt, pRt_old, free_cnt, fl_err
  );

  modport slave (
    input  dec_v, Ra, Rb, Rt, Rt_v, ren_rdy, cmt_v, cmt_preg,
    output dec_rdy, ren_v, pRa, pRb, pRt, pRt_old, free_cnt, fl_err
  );

endinterface

// File: rtl/qupls_rename_stage_free_list.sv
// Circular free list of physical registers. Resets full with 64..127; pushes
// of preg 0 are ignored and pushes into a full list are dropped (sticky err).
module qupls_free_list
  import qupls_rename_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pop,
  input  logic       push,
  input  pregspec_t  push_preg,
  output pregspec_t  head_preg,
  output logic [6:0] count,
  output logic       err
);

  pregspec_t  mem_q [NFREE];
  pregspec_t  mem_d [NFREE];
  logic [5:0] head_q, head_d;
  logic [5:0] tail_q, tail_d;
  logic [6:0] count_q, count_d;
  logic       err_q, err_d;
  logic       full_s;
  logic       push_ok_s;

  // next-state for storage, pointers, occupancy and overflow flag
  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    full_s    = (count_q == 7'd64);
    push_ok_s = push & (push_preg != 7'd0) & !full_s;
    if (push_ok_s) begin
      mem_d[tail_q] = push_preg;
      tail_d        = tail_q + 6'd1;
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = head_q + 6'd1;
    end else begin
      head_d = head_q;
    end
    count_d = count_q + {6'd0, push_ok_s} - {6'd0, pop};
    err_d   = err_q | (push & (push_preg != 7'd0) & full_s);
  end

  // state registers with reset preload of the upper physical registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NFREE; i++) begin
        mem_q[i] <= pregspec_t'(NAREG + i);
      end
      head_q  <= 6'd0;
      tail_q  <= 6'd0;
      count_q <= 7'd64;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign head_preg = mem_q[head_q];
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: rtl/qupls_rename_stage.sv
// Single-issue rename stage: RAT lookup, free-list allocation, registered
// valid/ready output. Define QUPLS_RENAME_BYPASS_EN to forward a commit straight
// into an allocation when the free list is empty.
module qupls_rename_stage
  import qupls_rename_stage_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  qupls_rename_stage_if.slave bus
);

  pregspec_t   rat_q [NAREG];
  pregspec_t   rat_d [NAREG];
  rename_out_t out_q, out_d;
  logic        ren_v_q, ren_v_d;

  logic        need_s, cmt_ok_s, fl_empty_s, byp_s, dec_rdy_s;
  logic        accept_s, alloc_s, pop_s, push_s;
  pregspec_t   new_preg_s, head_preg_s;
  logic [6:0]  free_cnt_s;
  logic        fl_err_s;

  // acceptance and free-list control
  always_comb begin
    need_s     = bus.Rt_v & (bus.Rt != 6'd0);
    cmt_ok_s   = bus.cmt_v & (bus.cmt_preg != 7'd0);
    fl_empty_s = (free_cnt_s == 7'd0);
`ifdef QUPLS_RENAME_BYPASS_EN
    byp_s      = need_s & fl_empty_s & cmt_ok_s;
    dec_rdy_s  = (!ren_v_q | bus.ren_rdy) & (!need_s | !fl_empty_s | cmt_ok_s);
`else
    byp_s      = 1'b0;
    dec_rdy_s  = (!ren_v_q | bus.ren_rdy) & (!need_s | !fl_empty_s);
`endif
    accept_s   = bus.dec_v & dec_rdy_s;
    alloc_s    = accept_s & need_s;
    pop_s      = alloc_s & !byp_s;
    // a bypassed commit is consumed by the allocation and never enters the list
    push_s     = bus.cmt_v & !(alloc_s & byp_s);
    new_preg_s = byp_s ? bus.cmt_preg : head_preg_s;
  end

  qupls_free_list u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop       (pop_s),
    .push      (push_s),
    .push_preg (bus.cmt_preg),
    .head_preg (head_preg_s),
    .count     (free_cnt_s),
    .err       (fl_err_s)
  );

  // RAT update and output register next-state; sources read the pre-update map
  always_comb begin
    rat_d   = rat_q;
    out_d   = out_q;
    ren_v_d = ren_v_q;
    if (accept_s) begin
      ren_v_d   = 1'b1;
      out_d.pRa = rat_q[bus.Ra];
      out_d.pRb = rat_q[bus.Rb];
      if (alloc_s) begin
        out_d.pRt     = new_preg_s;
        out_d.pRt_old = rat_q[bus.Rt];
        rat_d[bus.Rt] = new_preg_s;
      end else begin
        out_d.pRt     = 7'd0;
        out_d.pRt_old = 7'd0;
      end
    end else if (bus.ren_rdy) begin
      ren_v_d = 1'b0;
    end else begin
      ren_v_d = ren_v_q;
    end
  end

  // RAT and output registers; RAT resets to the identity map
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NAREG; i++) begin
        rat_q[i] <= pregspec_t'(i);
      end
      out_q   <= rename_out_t'(28'd0);
      ren_v_q <= 1'b0;
    end else begin
      rat_q   <= rat_d;
      out_q   <= out_d;
      ren_v_q <= ren_v_d;
    end
  end

  assign bus.dec_rdy  = dec_rdy_s;
  assign bus.ren_v    = ren_v_q;
  assign bus.pRa      = out_q.pRa;
  assign bus.pRb      = out_q.pRb;
  assign bus.pRt      = out_q.pRt;
  assign bus.pRt_old  = out_q.pRt_old;
  assign bus.free_cnt = free_cnt_s;
  assign bus.fl_err   = fl_err_s;

endmodule

// File: tb/tb_qupls_rename_stage.sv
// Scoreboard bench for qupls_rename_stage: a reference model built from an
// architectural map array and a free-list queue predicts each renamed output.
module tb_qupls_rename_stage;
  import qupls_rename_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qupls_rename_stage_if bus ();

  qupls_rename_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int pra;
    int prb;
    int prt;
    int prt_old;
  } exp_t;

  exp_t sb_q[$];
  int   m_rat [64];
  int   m_fl[$];
  bit   m_ren_v;
  bit   m_err;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_rat[i] = i;
    m_fl.delete();
    for (int i = 0; i < 64; i++) m_fl.push_back(64 + i);
    m_ren_v = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dec_v = 1'b0; bus.cmt_v = 1'b0; bus.ren_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    check("rst_ren_v", bus.ren_v, 0);
    check("rst_free_cnt", bus.free_cnt, 64);
    check("rst_fl_err", bus.fl_err, 0);
    check("rst_outs", {bus.pRa, bus.pRb, bus.pRt, bus.pRt_old}, 0);
  endtask

  // one clock of stimulus; model predicts handshake and the renamed result
  task automatic drive(input bit dv, input int ra, input int rb, input int rt,
                       input bit rtv, input bit rr, input bit cv, input int cp);
    bit   need, cmt_ok, rdy, accept, byp, was_full;
    exp_t e;
    @(posedge clk); #1;
    bus.dec_v = dv; bus.Ra = regspec_t'(ra); bus.Rb = regspec_t'(rb);
    bus.Rt = regspec_t'(rt); bus.Rt_v = rtv; bus.ren_rdy = rr;
    bus.cmt_v = cv; bus.cmt_preg = pregspec_t'(cp);
    #1;
    need   = rtv && (rt != 0);
    cmt_ok = cv && (cp != 0);
`ifdef QUPLS_RENAME_BYPASS_EN
    rdy = (!m_ren_v || rr) && (!need || m_fl.size() != 0 || cmt_ok);
`else
    rdy = (!m_ren_v || rr) && (!need || m_fl.size() != 0);
`endif
    check("dec_rdy", bus.dec_rdy, int'(rdy));
    check("ren_v", bus.ren_v, int'(m_ren_v));
    check("free_cnt", bus.free_cnt, m_fl.size());
    check("fl_err", bus.fl_err, int'(m_err));
    accept   = dv && rdy;
    was_full = (m_fl.size() == 64);
    byp      = 1'b0;
`ifdef QUPLS_RENAME_BYPASS_EN
    byp = accept && need && (m_fl.size() == 0) && cmt_ok;
`endif
    if (accept) begin
      e.pra = m_rat[ra];
      e.prb = m_rat[rb];
      if (need) begin
        e.prt     = byp ? cp : m_fl.pop_front();
        e.prt_old = m_rat[rt];
        m_rat[rt] = e.prt;
      end else begin
        e.prt = 0;
        e.prt_old = 0;
      end
      sb_q.push_back(e);
    end
    if (cmt_ok && !byp) begin
      if (was_full) m_err = 1'b1;
      else m_fl.push_back(cp);
    end
    if (accept) m_ren_v = 1'b1;
    else if (rr) m_ren_v = 1'b0;
  endtask

  // monitor: compare on handshake and require stable outputs while stalled
  bit          held = 1'b0;
  logic [27:0] held_val;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      held = 1'b0;
    end else begin
      if (held && bus.ren_v) check("hold_stable", {bus.pRa, bus.pRb, bus.pRt, bus.pRt_old}, int'(held_val));
      if (bus.ren_v === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("ren_v_unexpected", bus.ren_v, 0);
        end else if (bus.ren_rdy) begin
          exp_t e;
          e = sb_q.pop_front();
          check("pRa", bus.pRa, e.pra);
          check("pRb", bus.pRb, e.prb);
          check("pRt", bus.pRt, e.prt);
          check("pRt_old", bus.pRt_old, e.prt_old);
        end
        held     = !bus.ren_rdy;
        held_val = {bus.pRa, bus.pRb, bus.pRt, bus.pRt_old};
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    bus.dec_v = 1'b0; bus.Ra = 6'd0; bus.Rb = 6'd0; bus.Rt = 6'd0; bus.Rt_v = 1'b0;
    bus.ren_rdy = 1'b0; bus.cmt_v = 1'b0; bus.cmt_preg = 7'd0;
    model_reset();
    do_reset();

    // first allocation, then read back the new mapping; Rt=0 allocates nothing
    drive(1, 5, 3, 5, 1, 1, 0, 0);
    drive(1, 5, 0, 0, 0, 1, 0, 0);
    drive(1, 1, 2, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // drain the free list, stall on empty, refill with one commit
    do_reset();
    while (m_fl.size() > 0) drive(1, $urandom_range(63, 0), $urandom_range(63, 0), $urandom_range(63, 1), 1, 1, 0, 0);
    drive(1, 1, 2, 7, 1, 1, 0, 0);
    drive(1, 1, 2, 7, 1, 1, 1, 5);
    drive(1, 1, 2, 7, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // dispatch backpressure for three cycles
    do_reset();
    drive(1, 3, 4, 9, 1, 1, 0, 0);
    repeat (3) drive(1, 9, 4, 10, 1, 0, 0, 0);
    drive(1, 9, 4, 10, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // simultaneous allocate and commit at count 10, then overflow
    do_reset();
    repeat (54) drive(1, $urandom_range(63, 0), $urandom_range(63, 0), $urandom_range(63, 1), 1, 1, 0, 0);
    drive(1, 1, 1, 12, 1, 1, 1, 100);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("free_cnt_10", bus.free_cnt, 10);
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 70);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("fl_err_sticky", bus.fl_err, 1);

    // reset while an output is pending, then confirm identity map
    drive(1, 2, 3, 4, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 4, 63, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // randomized traffic
    repeat (3000) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(63, 0), $urandom_range(63, 0),
            $urandom_range(63, 0), $urandom_range(4, 0) != 0, $urandom_range(9, 0) < 7,
            $urandom_range(9, 0) < 3, $urandom_range(127, 0));
      if ($urandom_range(499, 0) == 0) do_reset();
    end

    repeat (4) drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qupls_rename_stage.md
Name: qupls_rename_stage

Overview:
- Single-issue register-rename stage directly downstream of the source/target register decoders (Ra, Rb, Rt).
- Consumes architectural register specs and maps them to physical registers through a register alias table (RAT).
- Allocates a new physical destination register from a free-list FIFO.
- Presents the renamed instruction to the dispatch stage through a registered valid/ready handshake. Commit returns freed physical registers.

Parameters:
- NAREG, 64, architectural registers; regspec_t width 6.
- NPREG, 128, physical registers; pregspec_t width 7.
- NFREE, NPREG-NAREG (64), free-list FIFO depth.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- dec_v  in  1  decoded instruction valid.
- dec_rdy  out  1  stage can accept this cycle.
- Ra  in  6  architectural source A (regspec_t).
- Rb  in  6  architectural source B.
- Rt  in  6  architectural target.
- Rt_v  in  1  instruction writes Rt.
- ren_v  out  1  renamed instruction valid.
- ren_rdy  in  1  dispatch accepts.
- pRa  out  7  physical source A.
- pRb  out  7  physical source B.
- pRt  out  7  newly allocated physical target (0 if no write).
- pRt_old  out  7  previous mapping of Rt (freed at commit).
- cmt_v  in  1  commit frees a register.
- cmt_preg  in  7  physical register to free.
- free_cnt  out  7  free-list occupancy.
- fl_err  out  1  sticky free-list overflow.

Behaviour:
- Reset:
  - RAT[i]=i for all i.
  - Free list holds 64..127 in order, head=0, tail=0, free_cnt=64.
  - ren_v=0; pRa, pRb, pRt, pRt_old = 0; fl_err=0.
- Acceptance:
  - accept = dec_v & dec_rdy.
  - need = Rt_v & (Rt!=0).
  - dec_rdy = (!ren_v | ren_rdy) & (!need | free_cnt!=0). Combinational from registered state only; no dependence on cmt_v.
- Latency 1 cycle: on accept, the next cycle has ren_v=1 with the following values:
  - pRa = RAT[Ra], pRb = RAT[Rb], read before this instruction's own RAT update, so Ra==Rt yields the old mapping.
  - Arch reg 0 always maps to preg 0.
  - If need: pRt = free-list head entry; pRt_old = RAT[Rt]; RAT[Rt] <= pRt; head++ (mod NFREE).
  - Else: pRt = 0, pRt_old = 0.
- Hold: when ren_v & !ren_rdy, all outputs hold stable. ren_v clears on ren_rdy & !accept.
- Commit: when cmt_v & cmt_preg!=0 & free_cnt<NFREE, write to free list at tail and tail++.
  - cmt_preg==0 is ignored.
  - A push attempted while free_cnt==NFREE is dropped and sets fl_err (cleared only by rst).
- Simultaneous allocate and commit: free_cnt unchanged, head and tail both advance.
  - A commit into an empty list does not make the register allocatable until the next cycle.
- free_cnt arithmetic is 7-bit (0..64). Pointers are 6-bit and wrap naturally.
- rst asserted mid-operation: the whole state is restored in that cycle and any in-flight ren_v is dropped.

Optional Feature:
- Macro QUPLS_RENAME_BYPASS_EN.
- With it: a commit to an empty list and an allocation in the same cycle are satisfied directly, so pRt = cmt_preg and the list is untouched. dec_rdy additionally includes (cmt_v & cmt_preg!=0) when free_cnt==0.
- Without it: behaviour is as above, and the stage stalls one cycle.

Decomposition:
- Shared QuplsPkg:
  - regspec_t, pregspec_t.
  - NAREG/NPREG constants.
  - A rename_out_t struct {pRa, pRb, pRt, pRt_old}.
- Sub-module qupls_free_list: circular FIFO with head, tail, count, overflow flag and reset initialisation. The RAT stays inline.

Test Plan:
- Reset, then Rt_v=1, Rt=5, Ra=5, Rb=3 -> next cycle ren_v=1, pRa=5, pRb=3, pRt=64, pRt_old=5. A following read of Ra=5 gives pRa=64.
- Rt=0 with Rt_v=1 -> pRt=0, pRt_old=0, free_cnt stays 64.
- 64 back-to-back allocations with no commits -> free_cnt=0. The 65th has dec_rdy=0 until cmt_v=1, cmt_preg=5, then it allocates pRt=5 one cycle later (same cycle with QUPLS_RENAME_BYPASS_EN).
- ren_rdy=0 for 3 cycles with dec_v=1 -> outputs stable, no allocation, head unchanged.
- Simultaneous accept and commit at free_cnt=10 -> free_cnt remains 10. With free_cnt=64, cmt_v=1, cmt_preg=70 -> fl_err=1 and stays set.
- rst pulse while ren_v=1 -> next cycle ren_v=0, free_cnt=64, RAT identity.
